// File: rtl/commit_trace_recorder_if.sv
// Record stream from the commit trace recorder to its log sink.
// The recorder drives the record fields; the sink returns out_ready.
interface commit_trace_recorder_if #(
    parameter int CNT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic             out_kind;
    logic [31:0]      out_pc;
    logic [31:0]      out_addr;
    logic [31:0]      out_data;
    logic [3:0]       out_byteen;
    logic [CNT_W-1:0] out_cycle;

    modport master (
        output out_valid, out_kind, out_pc, out_addr, out_data, out_byteen, out_cycle,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_kind, out_pc, out_addr, out_data, out_byteen, out_cycle,
        output out_ready
    );
endinterface

// File: rtl/commit_trace_recorder.sv
// Retire-trace recorder: captures register and memory commits from the core,
// time-stamps them, and drains them through a dual-push FIFO one per cycle.
module commit_trace_recorder #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    w_grf_we,
    input  logic [4:0]              w_grf_addr,
    input  logic [31:0]             w_grf_wdata,
    input  logic [31:0]             w_inst_addr,
    input  logic [3:0]              m_data_byteen,
    input  logic [31:0]             m_data_addr,
    input  logic [31:0]             m_data_wdata,
    input  logic [31:0]             m_inst_addr,
    commit_trace_recorder_if.master trace,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    typedef struct packed {
        logic             kind;
        logic [31:0]      pc;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [3:0]       byteen;
        logic [CNT_W-1:0] cycle;
    } rec_t;

    rec_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [CNT_FW-1:0] count;
    logic [CNT_FW-1:0] free_slots;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W:0]    drop_sum;
    logic [CNT_W-1:0]  drop_next;

    logic       m_ev;
    logic       g_ev;
    logic       head_valid;
    logic       pop;
    logic [1:0] n_req;
    logic [1:0] accept;
    logic [1:0] n_drop;
    logic [31:0] lane_mask;
    rec_t       m_rec;
    rec_t       g_rec;
    rec_t       first_rec;
    rec_t       head;

    assign m_ev = (m_data_byteen != 4'b0000);
    assign g_ev = w_grf_we && (w_grf_addr != 5'd0);

    assign lane_mask = {{8{m_data_byteen[3]}}, {8{m_data_byteen[2]}},
                        {8{m_data_byteen[1]}}, {8{m_data_byteen[0]}}};

    always_comb begin
        m_rec        = '0;
        m_rec.kind   = 1'b1;
        m_rec.pc     = m_inst_addr;
        m_rec.addr   = m_data_addr & 32'hFFFF_FFFC;
        m_rec.data   = m_data_wdata & lane_mask;
        m_rec.byteen = m_data_byteen;
        m_rec.cycle  = cycle_cnt;

        g_rec        = '0;
        g_rec.kind   = 1'b0;
        g_rec.pc     = w_inst_addr;
        g_rec.addr   = {27'b0, w_grf_addr};
        g_rec.data   = w_grf_wdata;
        g_rec.byteen = 4'b1111;
        g_rec.cycle  = cycle_cnt;

        // The memory record always goes first; a lone register record takes slot one.
        first_rec    = m_ev ? m_rec : g_rec;
    end

    assign head_valid = (count != '0);
    assign pop        = head_valid && trace.out_ready;
    assign wr_ptr_p1  = wr_ptr + PTR_W'(1);

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        accept     = 2'd0;
        n_req      = 2'(m_ev) + 2'(g_ev);
        // A pop this cycle frees its slot for a push in the same cycle.
        free_slots = CNT_FW'(DEPTH) - count + CNT_FW'(pop);
        if (free_slots >= CNT_FW'(n_req)) begin
            accept = n_req;
        end else begin
            accept = free_slots[1:0];
        end
        n_drop    = n_req - accept;
        drop_sum  = {1'b0, drop_count} + (CNT_W + 1)'(n_drop);
        drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cycle_cnt  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            wr_ptr    <= wr_ptr + PTR_W'(accept);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            count     <= count + CNT_FW'(accept) - CNT_FW'(pop);
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_next;
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an empty count masks any stale entry.
    always_ff @(posedge clk) begin
        if (accept != 2'd0) begin
            mem[wr_ptr] <= first_rec;
        end
        if (accept == 2'd2) begin
            mem[wr_ptr_p1] <= g_rec;
        end
    end

    assign head = mem[rd_ptr];

    assign trace.out_valid  = head_valid;
    assign trace.out_kind   = head_valid ? head.kind   : 1'b0;
    assign trace.out_pc     = head_valid ? head.pc     : 32'd0;
    assign trace.out_addr   = head_valid ? head.addr   : 32'd0;
    assign trace.out_data   = head_valid ? head.data   : 32'd0;
    assign trace.out_byteen = head_valid ? head.byteen : 4'd0;
    assign trace.out_cycle  = head_valid ? head.cycle  : '0;

endmodule

// File: tb/tb_commit_trace_recorder.sv
// Bench for commit_trace_recorder: directed scenarios plus randomized traffic
// checked against a queue-based model of the trace stream.
module tb_commit_trace_recorder;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic             valid;
        logic             kind;
        logic [31:0]      pc;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [3:0]       be;
        logic [CNT_W-1:0] cyc;
    } view_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             w_grf_we;
    logic [4:0]       w_grf_addr;
    logic [31:0]      w_grf_wdata;
    logic [31:0]      w_inst_addr;
    logic [3:0]       m_data_byteen;
    logic [31:0]      m_data_addr;
    logic [31:0]      m_data_wdata;
    logic [31:0]      m_inst_addr;
    logic             ready;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    commit_trace_recorder_if #(.CNT_W(CNT_W)) trace ();
    assign trace.out_ready = ready;

    commit_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .w_grf_we      (w_grf_we),
        .w_grf_addr    (w_grf_addr),
        .w_grf_wdata   (w_grf_wdata),
        .w_inst_addr   (w_inst_addr),
        .m_data_byteen (m_data_byteen),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_inst_addr   (m_inst_addr),
        .trace         (trace),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: the trace stream as a queue of records.
    view_t            q[$];
    logic [CNT_W-1:0] m_cycle;
    logic [CNT_W-1:0] m_drops;
    logic             m_ovf;
    int               n_checks = 0;
    int               n_fail = 0;

    function automatic view_t observed();
        view_t v;
        v.valid = trace.out_valid;
        v.kind  = trace.out_kind;
        v.pc    = trace.out_pc;
        v.addr  = trace.out_addr;
        v.data  = trace.out_data;
        v.be    = trace.out_byteen;
        v.cyc   = trace.out_cycle;
        return v;
    endfunction

    function automatic view_t expected();
        if (q.size() == 0) return '0;
        return q[0];
    endfunction

    function automatic view_t mk(input logic kind, input logic [31:0] pc, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] be,
                                 input logic [CNT_W-1:0] cyc);
        view_t v;
        v.valid = 1'b1;
        v.kind  = kind;
        v.pc    = pc;
        v.addr  = addr;
        v.data  = data;
        v.be    = be;
        v.cyc   = cyc;
        return v;
    endfunction

    task automatic model_push(input view_t r);
        if (q.size() < DEPTH) begin
            q.push_back(r);
        end else begin
            m_ovf = 1'b1;
            if (m_drops != '1) m_drops = m_drops + 1;
        end
    endtask

    task automatic drive_idle();
        w_grf_we      = 1'b0;
        w_grf_addr    = 5'd0;
        w_grf_wdata   = 32'd0;
        w_inst_addr   = 32'd0;
        m_data_byteen = 4'd0;
        m_data_addr   = 32'd0;
        m_data_wdata  = 32'd0;
        m_inst_addr   = 32'd0;
    endtask

    task automatic set_grf(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        w_grf_we    = 1'b1;
        w_grf_addr  = a;
        w_grf_wdata = d;
        w_inst_addr = pc;
    endtask

    task automatic set_mem(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] pc);
        m_data_byteen = be;
        m_data_addr   = a;
        m_data_wdata  = d;
        m_inst_addr   = pc;
    endtask

    // Advance the model by one edge from the current inputs, then move to the next falling edge.
    task automatic tick();
        view_t r;
        logic [31:0] masked;
        if (q.size() > 0 && ready) void'(q.pop_front());
        if (m_data_byteen != 4'd0) begin
            masked = 32'd0;
            for (int b = 0; b < 4; b++)
                if (m_data_byteen[b]) masked = masked | (m_data_wdata & (32'hFF << (8 * b)));
            r = mk(1'b1, m_inst_addr, m_data_addr - (m_data_addr % 4), masked, m_data_byteen, m_cycle);
            model_push(r);
        end
        if (w_grf_we && w_grf_addr != 5'd0) begin
            r = mk(1'b0, w_inst_addr, 32'(w_grf_addr), w_grf_wdata, 4'hF, m_cycle);
            model_push(r);
        end
        m_cycle = m_cycle + 1;
        @(negedge clk);
    endtask

    task automatic model_clear();
        q.delete();
        m_cycle = '0;
        m_drops = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        ready = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        view_t obs;
        @(negedge clk);
        @(negedge clk);
        obs = observed();
        n_checks++;
        if (obs !== view_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        n_checks++;
        if (overflow !== 1'b0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL reset_drop: got ovf=%b drops=%0d want 0/0", overflow, drop_count);
        end
        model_clear();
        reset = 1'b1;
    endtask

    task automatic test_single_reg();
        view_t obs;
        view_t want;
        apply_reset();
        repeat (3) tick();
        ready = 1'b1;
        set_grf(5'd5, 32'h1234_5678, 32'h0000_3004);
        tick();
        drive_idle();
        obs  = observed();
        want = mk(1'b0, 32'h3004, 32'd5, 32'h1234_5678, 4'hF, 32'd3);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL single_reg: got %h want %h", obs, want);
        end
        tick();
        n_checks++;
        if (trace.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_reg_one_cycle: got valid=%b want 0", trace.out_valid);
        end
    endtask

    task automatic test_zero_filter_store();
        view_t obs;
        view_t want;
        logic [CNT_W-1:0] c0;
        ready = 1'b1;
        set_grf(5'd0, 32'hDEAD_BEEF, 32'h3008);
        set_mem(4'b0100, 32'h0000_000E, 32'hAABB_CCDD, 32'h3008);
        c0 = m_cycle;
        tick();
        drive_idle();
        obs  = observed();
        want = mk(1'b1, 32'h3008, 32'h0000_000C, 32'h00BB_0000, 4'b0100, c0);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL byte_store: got %h want %h", obs, want);
        end
        tick();
        n_checks++;
        if (trace.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_filter: got valid=%b want 0", trace.out_valid);
        end
    endtask

    task automatic test_simultaneous();
        view_t obs;
        view_t want;
        logic [CNT_W-1:0] c0;
        ready = 1'b1;
        set_mem(4'hF, 32'h0000_0100, 32'h1122_3344, 32'h3010);
        set_grf(5'd7, 32'h5566_7788, 32'h300C);
        c0 = m_cycle;
        tick();
        drive_idle();
        obs  = observed();
        want = mk(1'b1, 32'h3010, 32'h100, 32'h1122_3344, 4'hF, c0);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL dual_first_mem: got %h want %h", obs, want);
        end
        tick();
        obs  = observed();
        want = mk(1'b0, 32'h300C, 32'd7, 32'h5566_7788, 4'hF, c0);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL dual_second_reg: got %h want %h", obs, want);
        end
        tick();
    endtask

    task automatic test_overflow();
        view_t obs;
        view_t want;
        ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_grf(5'(1 + (i % 31)), $urandom, 32'h4000 + 32'(4 * i));
            tick();
        end
        drive_idle();
        n_checks++;
        if (overflow !== 1'b1 || drop_count !== 32'd3) begin
            n_fail++;
            $display("FAIL overflow_count: got ovf=%b drops=%0d want 1/3", overflow, drop_count);
        end
        ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            obs  = observed();
            want = expected();
            n_checks++;
            if (obs !== want || obs.pc !== 32'h4000 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got %h want %h", i, obs, want);
            end
            tick();
        end
        n_checks++;
        if (trace.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drain_end: got valid=%b want 0", trace.out_valid);
        end
    endtask

    task automatic test_full_with_pop();
        view_t obs;
        view_t want;
        logic [CNT_W-1:0] drops_before;
        int n_out;
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_grf(5'd9, 32'hA000 + 32'(i), 32'h5000 + 32'(4 * i));
            tick();
        end
        drive_idle();
        drops_before = m_drops;
        ready = 1'b1;
        set_mem(4'b0011, 32'h0000_0203, 32'hCAFE_F00D, 32'h6000);
        set_grf(5'd10, 32'h0BAD_0BAD, 32'h6004);
        tick();
        drive_idle();
        ready = 1'b0;
        n_checks++;
        if (drop_count !== drops_before + 1) begin
            n_fail++;
            $display("FAIL full_pop_drop: got %0d want %0d", drop_count, drops_before + 1);
        end
        obs = observed();
        n_checks++;
        if (obs !== expected() || obs.pc !== 32'h5004) begin
            n_fail++;
            $display("FAIL full_pop_head: got %h want %h", obs, expected());
        end
        ready = 1'b1;
        n_out = 0;
        want  = '0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (trace.out_valid !== 1'b1) break;
            want = observed();
            n_out++;
            tick();
        end
        n_checks++;
        if (n_out != DEPTH || want.kind !== 1'b1 || want.data !== 32'h0000_F00D) begin
            n_fail++;
            $display("FAIL full_pop_count: got %0d records last=%h want %0d ending with store",
                     n_out, want, DEPTH);
        end
    endtask

    task automatic test_random();
        view_t obs;
        view_t want;
        for (int i = 0; i < 400; i++) begin
            drive_idle();
            ready = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 2) != 0)
                set_grf(5'($urandom_range(0, 31)), $urandom, $urandom);
            if ($urandom_range(0, 1) != 0)
                set_mem(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom);
            tick();
            obs  = observed();
            want = expected();
            n_checks++;
            if (obs !== want || overflow !== m_ovf || drop_count !== m_drops) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h ovf=%b drops=%0d want %h ovf=%b drops=%0d",
                         i, obs, overflow, drop_count, want, m_ovf, m_drops);
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        view_t obs;
        view_t want;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_grf(5'd3, 32'h7000 + 32'(i), 32'h7100 + 32'(4 * i));
            tick();
        end
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        obs = observed();
        n_checks++;
        if (obs !== view_t'(0) || overflow !== 1'b0 || drop_count !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h ovf=%b drops=%0d want all 0", obs, overflow, drop_count);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        set_grf(5'd4, 32'h0000_0044, 32'h8000);
        tick();
        drive_idle();
        obs  = observed();
        want = mk(1'b0, 32'h8000, 32'd4, 32'h44, 4'hF, 32'd0);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL post_reset_record: got %h want %h", obs, want);
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (trace.out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_stale: got valid=%b ovf=%b want 0/0", trace.out_valid, overflow);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ready = 1'b0;
        drive_idle();
        model_clear();
        #1 reset = 1'b0;
        test_reset();
        test_single_reg();
        test_zero_filter_store();
        test_simultaneous();
        test_overflow();
        test_full_with_pop();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_recorder.md
Name: commit_trace_recorder

Overview:
- Synthesizable retire-trace recorder attached directly downstream of the `mips` core's commit outputs.
- Captures register-file writes (`w_grf_*`) and data-memory writes (`m_data_*`) each cycle and time-stamps them.
- Buffers the records in a dual-push FIFO and drains them one per cycle over a valid/ready port to a log sink (UART bridge or bench monitor).
- Replaces `$display`-based tracing on FPGA builds.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- CNT_W, 32, width of the cycle stamp and of the drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- w_grf_we  in  1  core register-file write strobe.
- w_grf_addr  in  5  destination register.
- w_grf_wdata  in  32  register write data.
- w_inst_addr  in  32  PC of the writing instruction.
- m_data_byteen  in  4  store byte enables; nonzero means a store.
- m_data_addr  in  32  store byte address.
- m_data_wdata  in  32  store data, already lane-aligned.
- m_inst_addr  in  32  PC of the storing instruction.
- out_valid  out  1  record available.
- out_ready  in  1  sink accepts the record.
- out_kind  out  1  0 = register write, 1 = memory write.
- out_pc  out  32  instruction PC.
- out_addr  out  32  register number zero-extended, or word-aligned store address.
- out_data  out  32  record data.
- out_byteen  out  4  byte enables; 4'b1111 for register records.
- out_cycle  out  CNT_W  cycle stamp of capture.
- overflow  out  1  sticky: at least one record dropped.
- drop_count  out  CNT_W  number of records dropped, saturating.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO emptied; out_valid=0.
  - All out_* data fields = 0.
  - overflow=0, drop_count=0, cycle counter=0.
  - Reset mid-drain discards all buffered records.
- Cycle counter:
  - Increments by 1 every clk edge while reset is high; wraps at 2^CNT_W.
  - A record captured at edge N carries the counter value held before that edge.
- Event qualification, sampled on every rising edge:
  - Memory event (M): m_data_byteen != 0.
  - Register event (G): w_grf_we=1 and w_grf_addr != 0. Writes to $0 are never recorded.
- Record formation:
  - M: kind=1, pc=m_inst_addr, addr=m_data_addr & 32'hFFFFFFFC, byteen=m_data_byteen.
  - M data: m_data_wdata with every disabled byte lane forced to 8'h00.
  - G: kind=0, pc=w_inst_addr, addr={27'b0, w_grf_addr}, data=w_grf_wdata, byteen=4'b1111.
- Push ordering: when M and G occur in the same cycle, M is enqueued first and G second, giving two pushes in one cycle.
- Capacity:
  - Free slots this cycle = DEPTH − count + (out_valid & out_ready), so a pop frees a slot usable in the same cycle.
  - Records are accepted in push order while free slots remain.
  - Each record that does not fit is dropped: overflow set to 1, drop_count += 1 per dropped record (up to 2 per cycle), saturating at all-ones.
- Output handshake:
  - out_valid = (count != 0); out_* fields reflect the head entry combinationally from FIFO storage.
  - The head is popped on a cycle with out_valid & out_ready.
  - out_* fields hold stable while out_valid=1 and out_ready=0.
- Latency: a record captured at edge N is visible on out_* after edge N if the FIFO was empty; no bypass from the inputs.
- Count update: count_next = count + pushes − pop, with pushes in 0..2 and pop in 0..1. Pointers wrap modulo DEPTH.
- Full with pop: with count=DEPTH and a pop in the cycle, one push is accepted. If a second push arrives that cycle, it is dropped.
- overflow and drop_count clear only on reset.

Test Plan:
- Single register write: w_grf_we=1, addr=5, wdata=32'h12345678, pc=32'h3004 at cycle 3, out_ready=1.
  -> One record: kind=0, addr=5, data=32'h12345678, byteen=4'hF, cycle=3, out_valid high for exactly 1 cycle.
- $0 filter plus byte store:
  - Stimulus: w_grf_addr=0, we=1; same cycle byteen=4'b0100, m_data_addr=32'h0000000E, wdata=32'hAABBCCDD.
  - Required: only a memory record, with addr=32'h0000000C and data=32'h00BB0000.
- Simultaneous events: M (pc=32'h3010) and G (pc=32'h300C) in the same cycle.
  -> Two records, M then G, both with the same out_cycle.
- Backpressure and overflow: out_ready=0; inject 1 register event per cycle for DEPTH+3 cycles.
  -> DEPTH records retained in order, overflow=1, drop_count=3. Raising out_ready drains exactly DEPTH records in original order.
- Full with pop:
  - Stimulus: FIFO full, out_ready=1; one cycle with both M and G.
  - Required: head popped, M accepted, G dropped, drop_count +1, count remains DEPTH.
- Reset mid-operation: 5 records buffered, pull reset low asynchronously between clock edges.
  -> out_valid=0 immediately. After release: no stale records, out_cycle restarts from 0, overflow=0.
